// File: rtl/discr_scaler_ctrl_pkg.sv
// Shared encodings and constants for the discriminator scaler sequencer.
package discr_scaler_pkg;

  localparam int unsigned OVR_W    = 16;
  localparam int unsigned MAX_CHAN = 16;
  localparam logic [3:0]  HDR_CHAN = 4'hF;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } win_state_t;

  typedef enum logic {
    S_RD_IDLE,
    S_RD_SEND
  } rd_state_t;

endpackage

// File: rtl/discr_scaler_ctrl_if.sv
// Snapshot readout stream: one counter word per transfer, valid/ready handshake.
interface discr_scaler_ctrl_if #(
  parameter int P_CNT_WIDTH = 32
);
  logic                   valid;
  logic                   ready;
  logic [P_CNT_WIDTH-1:0] data;
  logic [3:0]             chan;
  logic                   last;
  logic                   hdr;

  modport master (output valid, data, chan, last, hdr, input ready);
  modport slave  (input valid, data, chan, last, hdr, output ready);
endinterface

// File: rtl/discr_scaler_ctrl_window_timer.sv
// Window period counter: loads 0, counts up while running, and registers a
// one-cycle terminal pulse (also forced by a stop request) plus a capture strobe.
module window_timer #(
  parameter int P_PER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_load,
  input  logic                   i_run,
  input  logic                   i_stop,
  input  logic [P_PER_WIDTH-1:0] i_period,
  output logic                   o_wrap,
  output logic                   o_pulse,
  output logic                   o_cap
);

  localparam logic [P_PER_WIDTH-1:0] L_ONE = P_PER_WIDTH'(1);

  logic [P_PER_WIDTH-1:0] r_cnt;
  logic                   r_pulse;
  logic                   r_cap;
  logic                   w_wrap;

  // Equality compare: a period shrunk below the count lets it run to all-ones.
  assign w_wrap  = i_run && (r_cnt == (i_period - L_ONE));
  assign o_wrap  = w_wrap;
  assign o_pulse = r_pulse;
  assign o_cap   = r_cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_cap   <= 1'b0;
    end else begin
      r_pulse <= w_wrap | i_stop;
      r_cap   <= w_wrap;
      if (i_load || w_wrap) begin
        r_cnt <= '0;
      end else if (i_run) begin
        r_cnt <= r_cnt + L_ONE;
      end
    end
  end

endmodule

// File: rtl/discr_scaler_ctrl.sv
// Discriminator scaler sequencer: counting windows, snapshot readout, inhibit length.
// Optional header word per readout when DISCR_SCALER_CTRL_HDR_EN is defined.
//
// state     | meaning
// S_IDLE    | windows stopped, inhibit_len follows pending config
// S_RUN     | window timer counting, cnt_clr every period cycles
// S_RD_IDLE | no readout in flight, next capture is accepted
// S_RD_SEND | streaming snapshot words, one per handshake
module discr_scaler_ctrl
  import discr_scaler_pkg::*;
#(
  parameter int P_N_CHAN    = 4,
  parameter int P_N_WIDTH   = 32,
  parameter int P_CNT_WIDTH = 32,
  parameter int P_PER_WIDTH = 32,
  parameter int P_SEQ_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_enable,
  input  logic [P_PER_WIDTH-1:0]          i_period,
  input  logic [P_N_WIDTH-1:0]            i_inhibit_len_req,
  input  logic                            i_cfg_update,
  output logic [P_N_WIDTH-1:0]            o_inhibit_len,
  input  logic [P_N_CHAN*P_CNT_WIDTH-1:0] i_counts_in,
  output logic                            o_cnt_clr,
  discr_scaler_ctrl_if.master             rd,
  output logic [P_SEQ_WIDTH-1:0]          o_window_seq,
  output logic [OVR_W-1:0]                o_overrun_cnt
);

  localparam logic [3:0]             L_LAST    = 4'(P_N_CHAN - 1);
  localparam logic [P_SEQ_WIDTH-1:0] L_SEQ_ONE = P_SEQ_WIDTH'(1);
  localparam logic [OVR_W-1:0]       L_OVR_ONE = OVR_W'(1);

  win_state_t r_win, w_win_nxt;
  rd_state_t  r_rd, w_rd_nxt;

  logic w_load, w_run, w_stop, w_wrap, w_cap;
  logic w_take, w_adv, w_drop, w_hs, w_valid, w_is_hdr, w_last_word;

  logic [P_N_WIDTH-1:0]            r_pend, r_inh;
  logic [P_SEQ_WIDTH-1:0]          r_seq, w_seq_nxt;
  logic [OVR_W-1:0]                r_ovr;
  logic [P_N_CHAN*P_CNT_WIDTH-1:0] r_snap;
  logic [3:0]                      r_chan;
  logic [P_CNT_WIDTH-1:0]          w_hdr_data;

  window_timer #(.P_PER_WIDTH(P_PER_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_run    (w_run),
    .i_stop   (w_stop),
    .i_period (i_period),
    .o_wrap   (w_wrap),
    .o_pulse  (o_cnt_clr),
    .o_cap    (w_cap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win <= S_IDLE;
      r_rd  <= S_RD_IDLE;
    end else begin
      r_win <= w_win_nxt;
      r_rd  <= w_rd_nxt;
    end
  end

  always_comb begin
    w_win_nxt = r_win;
    w_load    = 1'b0;
    w_run     = 1'b0;
    w_stop    = 1'b0;
    case (r_win)
      S_IDLE: begin
        if (i_enable && (i_period != '0)) begin
          w_win_nxt = S_RUN;
          w_load    = 1'b1;
        end
      end
      S_RUN: begin
        if (!i_enable || (i_period == '0)) begin
          w_win_nxt = S_IDLE;
          w_stop    = 1'b1;
        end else begin
          w_run = 1'b1;
        end
      end
      default: w_win_nxt = S_IDLE;
    endcase
  end

  // New inhibit length lands together with a counter clear, never mid-window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      r_inh  <= '0;
    end else begin
      if ((r_win == S_IDLE) || w_wrap || w_stop) begin
        r_inh <= r_pend;
      end
      if (i_cfg_update) begin
        r_pend <= i_inhibit_len_req;
      end
    end
  end

  assign w_seq_nxt = r_seq + L_SEQ_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= '0;
      r_ovr <= '0;
    end else if (w_cap) begin
      r_seq <= w_seq_nxt;
      if (w_drop && (r_ovr != '1)) begin
        r_ovr <= r_ovr + L_OVR_ONE;
      end
    end
  end

  assign w_valid     = (r_rd == S_RD_SEND);
  assign w_hs        = w_valid && rd.ready;
  assign w_last_word = !w_is_hdr && (r_chan == L_LAST);

  // A capture on the final handshake restarts the stream with no idle gap.
  always_comb begin
    w_rd_nxt = r_rd;
    w_take   = 1'b0;
    w_adv    = 1'b0;
    case (r_rd)
      S_RD_IDLE: begin
        if (w_cap) begin
          w_rd_nxt = S_RD_SEND;
          w_take   = 1'b1;
        end
      end
      S_RD_SEND: begin
        if (w_hs) begin
          if (w_last_word) begin
            if (w_cap) begin
              w_take = 1'b1;
            end else begin
              w_rd_nxt = S_RD_IDLE;
            end
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: w_rd_nxt = S_RD_IDLE;
    endcase
  end

  assign w_drop = w_cap && !w_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap <= '0;
      r_chan <= '0;
    end else if (w_take) begin
      r_snap <= i_counts_in;
      r_chan <= '0;
    end else if (w_adv && !w_is_hdr) begin
      r_chan <= r_chan + 4'd1;
    end
  end

`ifdef DISCR_SCALER_CTRL_HDR_EN
  localparam int L_HW = OVR_W + P_SEQ_WIDTH;

  logic            r_is_hdr;
  logic [L_HW-1:0] r_hdr_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_hdr  <= 1'b0;
      r_hdr_raw <= '0;
    end else if (w_take) begin
      r_is_hdr  <= 1'b1;
      r_hdr_raw <= {r_ovr, w_seq_nxt};
    end else if (w_adv) begin
      r_is_hdr  <= 1'b0;
    end
  end

  assign w_is_hdr = r_is_hdr;

  if (P_CNT_WIDTH > L_HW) begin : g_hdr_ext
    assign w_hdr_data = {{(P_CNT_WIDTH - L_HW){1'b0}}, r_hdr_raw};
  end else begin : g_hdr_trunc
    assign w_hdr_data = r_hdr_raw[P_CNT_WIDTH-1:0];
  end
`else
  assign w_is_hdr   = 1'b0;
  assign w_hdr_data = '0;
`endif

  assign rd.valid = w_valid;
  assign rd.data  = w_is_hdr ? w_hdr_data : r_snap[int'(r_chan)*P_CNT_WIDTH +: P_CNT_WIDTH];
  assign rd.chan  = w_is_hdr ? HDR_CHAN : r_chan;
  assign rd.last  = w_valid && w_last_word;
  assign rd.hdr   = w_is_hdr;

  assign o_inhibit_len = r_inh;
  assign o_window_seq  = r_seq;
  assign o_overrun_cnt = r_ovr;

endmodule

// File: tb/tb_discr_scaler_ctrl.sv
// Scoreboard bench for discr_scaler_ctrl: reference model of windows and readout
// queues expected words; a negedge monitor compares outputs and popped words.
module tb_discr_scaler_ctrl;

  localparam int N  = 4;
  localparam int CW = 32;
  localparam int PW = 32;
  localparam int IW = 32;
  localparam int SW = 16;
`ifdef DISCR_SCALER_CTRL_HDR_EN
  localparam int NWORDS = N + 1;
`else
  localparam int NWORDS = N;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [PW-1:0] per = '0;
  logic [IW-1:0] req = '0;
  logic          cfg = 1'b0;
  logic [N*CW-1:0] counts = '0;
  logic [IW-1:0] inh;
  logic          cnt_clr;
  logic [SW-1:0] seq;
  logic [15:0]   ovr;

  discr_scaler_ctrl_if #(.P_CNT_WIDTH(CW)) rd_if ();

  discr_scaler_ctrl #(
    .P_N_CHAN(N), .P_N_WIDTH(IW), .P_CNT_WIDTH(CW), .P_PER_WIDTH(PW), .P_SEQ_WIDTH(SW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_enable          (en),
    .i_period          (per),
    .i_inhibit_len_req (req),
    .i_cfg_update      (cfg),
    .o_inhibit_len     (inh),
    .i_counts_in       (counts),
    .o_cnt_clr         (cnt_clr),
    .rd                (rd_if.master),
    .o_window_seq      (seq),
    .o_overrun_cnt     (ovr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: windows are counted as edges since the run started.
  bit          m_run = 0, m_pulse = 0, m_pw = 0;
  int          m_edges = 0, m_words = 0;
  logic [15:0] m_seq = '0, m_ovr = '0;
  logic [IW-1:0] m_pend = '0, m_inh = '0;
  logic [37:0] sb[$];

  bit b_cap, b_hs, b_upd, b_np, b_npw;
  int b_after;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_pulse = 0; m_pw = 0; m_edges = 0; m_words = 0;
      m_seq = '0; m_ovr = '0; m_pend = '0; m_inh = '0;
      sb.delete();
    end else begin
      b_cap   = m_pulse && m_pw;
      b_hs    = (m_words > 0) && rd_if.ready;
      b_after = m_words - (b_hs ? 1 : 0);
      if (b_cap) begin
        m_seq = m_seq + 16'd1;
        if (b_after == 0) begin
`ifdef DISCR_SCALER_CTRL_HDR_EN
          sb.push_back({1'b1, 1'b0, 4'hF, m_ovr, m_seq});
`endif
          for (int k = 0; k < N; k++)
            sb.push_back({1'b0, (k == N - 1), 4'(k), counts[k*CW +: CW]});
          b_after = b_after + NWORDS;
        end else if (m_ovr != 16'hFFFF) begin
          m_ovr = m_ovr + 16'd1;
        end
      end
      m_words = b_after;
      b_np = 0; b_npw = 0; b_upd = !m_run;
      if (m_run) begin
        if (!en || per == 0) begin
          m_run = 0; b_np = 1; b_upd = 1;
        end else begin
          m_edges++;
          if (m_edges % per == 0) begin
            b_np = 1; b_npw = 1; b_upd = 1;
          end
        end
      end else if (en && per != 0) begin
        m_run = 1; m_edges = 0;
      end
      if (b_upd) m_inh = m_pend;
      if (cfg) m_pend = req;
      m_pulse = b_np;
      m_pw    = b_npw;
    end
  end

  logic [37:0] exp_w;
  always @(negedge clk) begin
    if (chk_on) begin
      check("cnt_clr", cnt_clr, m_pulse);
      check("inhibit_len", inh, m_inh);
      check("window_seq", seq, m_seq);
      check("overrun_cnt", ovr, m_ovr);
      check("rd_valid", rd_if.valid, m_words > 0);
      if (rd_if.valid && rd_if.ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_word: got chan %0h data %0h, expected no word", rd_if.chan, rd_if.data);
        end else begin
          exp_w = sb.pop_front();
          check("rd_word", {rd_if.hdr, rd_if.last, rd_if.chan, rd_if.data}, exp_w);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_counts_base;
    for (int k = 0; k < N; k++) counts[k*CW +: CW] = CW'(k + 100);
  endtask

  int lim, cyc;

  initial begin
    rd_if.ready = 1'b0;
    tick(1);
    chk_on = 1'b1;
    tick(2);
    rst = 1'b0;

    // fixed counts, period 10, always ready
    set_counts_base();
    rd_if.ready = 1'b1;
    per = 10; en = 1'b1;
    tick(60);

    // period 4 with a stalled reader: held first readout, later windows dropped
    en = 1'b0; tick(1);
    per = 4; en = 1'b1; rd_if.ready = 1'b0;
    tick(24);
    rd_if.ready = 1'b1;
    tick(20);

    // inhibit update mid-window, then while idle
    en = 1'b0; tick(1);
    per = 16; en = 1'b1; tick(5);
    req = 7; cfg = 1'b1; tick(1); cfg = 1'b0;
    tick(30);
    en = 1'b0; tick(2);
    req = 9; cfg = 1'b1; tick(1); cfg = 1'b0;
    tick(3);

    // enable dropped mid-window, then re-enabled
    per = 10; en = 1'b1; tick(26);
    en = 1'b0; tick(3);
    en = 1'b1; tick(25);

    // randomized phases; period only changes while idle
    for (int ph = 0; ph < 12; ph++) begin
      en  = 1'b0;
      per = ($urandom_range(0, 9) == 0) ? '0 : PW'($urandom_range(1, 12));
      tick($urandom_range(1, 3));
      en  = 1'b1;
      lim = $urandom_range(20, 80);
      for (int c = 0; c < lim; c++) begin
        rd_if.ready = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < N; k++) counts[k*CW +: CW] = $urandom;
        cfg = ($urandom_range(0, 9) == 0);
        req = $urandom;
        en  = ($urandom_range(0, 30) != 0);
        tick(1);
      end
      cfg = 1'b0;
    end

    // reset in the middle of a readout
    en = 1'b0; rd_if.ready = 1'b1; tick(1);
    req = 5; cfg = 1'b1; tick(1); cfg = 1'b0;
    per = 6; en = 1'b1;
    cyc = 0;
    while (m_words != NWORDS - 2 && cyc < 100) begin
      tick(1);
      cyc++;
    end
    check("reach_word2_timeout", cyc < 100, 1'b1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rst_rd_valid", rd_if.valid, 1'b0);
    check("rst_inhibit_len", inh, '0);
    check("rst_window_seq", seq, '0);
    check("rst_overrun_cnt", ovr, '0);
    check("rst_cnt_clr", cnt_clr, 1'b0);
    per = 3; tick(30);

    // drain
    en = 1'b0; rd_if.ready = 1'b1;
    cyc = 0;
    while (m_words != 0 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("drain_timeout", cyc < 200, 1'b1);
    tick(3);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/discr_scaler_ctrl.md
# discr_scaler_ctrl

Sequencer for the discriminator scaler datapath. Defines fixed-length counting windows for P_N_CHAN per-channel discriminator counters that sit behind the inhibit generators. At each window boundary it snapshots and clears those counters and streams the snapshot out one channel per word over a valid/ready interface. It also distributes the inhibit length to the inhibit generators, applying updates only at window boundaries.

## Interface
- P_N_CHAN, 4: number of discriminator channels (1–16)
- P_N_WIDTH, 32: inhibit length width
- P_CNT_WIDTH, 32: per-channel counter width
- P_PER_WIDTH, 32: window period width
- P_SEQ_WIDTH, 16: window sequence number width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run windows while high
- period  in  P_PER_WIDTH  window length in clk cycles; 0 = hold idle
- inhibit_len_req  in  P_N_WIDTH  requested inhibit length
- cfg_update  in  1  pulse: latch inhibit_len_req as pending
- inhibit_len  out  P_N_WIDTH  to all inhibit generators; reset 0
- counts_in  in  P_N_CHAN*P_CNT_WIDTH  live counter values, channel 0 in LSBs
- cnt_clr  out  1  counter clear/load-increment strobe; reset 0
- rd_valid  out  1  reset 0
- rd_ready  in  1
- rd_data  out  P_CNT_WIDTH  reset 0
- rd_chan  out  4  channel index of rd_data; reset 0
- rd_last  out  1  final word of window; reset 0
- rd_hdr  out  1  header word flag; reset 0
- window_seq  out  P_SEQ_WIDTH  completed-window count; reset 0
- overrun_cnt  out  16  dropped snapshots, saturating; reset 0

## Operation
- Window FSM: S_IDLE, S_RUN. S_IDLE→S_RUN when enable && period!=0; timer loads 0.
- S_RUN: timer increments each cycle. At timer==period-1, the timer wraps to 0 and cnt_clr is registered high for the next cycle.
- On the edge ending a cnt_clr=1 cycle, external counters load that cycle's increment. No counts are lost; each window is exactly period cycles.
- On that same edge, the snapshot is captured if the readout is free. window_seq increments (wraps) regardless.
- Readout busy at capture edge: snapshot dropped, overrun_cnt += 1 (saturate at 0xFFFF), current readout unaffected.
- enable low or period==0 in S_RUN: go to S_IDLE and emit one cnt_clr pulse. No snapshot, no seq increment. Any in-flight readout completes.
- inhibit_len: cfg_update stores inhibit_len_req in a pending register, overwriting any earlier pending value.
  - In S_RUN, inhibit_len takes the pending value on the edge where cnt_clr goes high.
  - In S_IDLE, it takes the value on the next edge.
- Readout FSM: S_RD_IDLE, S_RD_SEND. A word transfers when rd_valid && rd_ready.
  - Words go out in channel order 0..P_N_CHAN-1; rd_last is set on channel P_N_CHAN-1.
  - rd_valid stays high and rd_data/rd_chan stay stable until accepted.
- Readout counts as free at a capture edge if it is in S_RD_IDLE, or if the final handshake occurs on that same edge.
- rst mid-operation: all state and outputs return to reset values; the pending config is cleared to 0.

## Timing
- cnt_clr: one cycle wide, every period cycles.
- First cnt_clr: period cycles after the S_IDLE→S_RUN edge.
- period==1: cnt_clr is continuously high.
- First rd_valid: the cycle after the capture edge.
- Back-to-back readout: one word per cycle with rd_ready held high.
- A capture coinciding with the final handshake produces the new first word on the next cycle, with no gap.
- period and enable are sampled every cycle. A period change in S_RUN takes effect at the next timer wrap comparison.
  - If the new period ≤ the current timer value, the timer runs on to all-ones and wraps. This is intended behaviour.

## Configuration
- DISCR_SCALER_CTRL_HDR_EN defined: each readout is preceded by one header word.
  - Header flags: rd_hdr=1, rd_chan=0xF, rd_last=0.
  - Header rd_data = {overrun_cnt, window_seq of this snapshot}, zero-extended/truncated to P_CNT_WIDTH.
  - Readout is P_N_CHAN+1 words.
- Undefined: no header. rd_hdr is tied 0 and readout is P_N_CHAN words.

## Structure
- Package discr_scaler_pkg holds:
  - window and readout state encodings
  - header rd_chan constant 0xF
  - overrun counter width 16
  - P_N_CHAN upper bound
- Sub-module window_timer: period counter with enable, synchronous load, and a registered terminal pulse. It drives cnt_clr and the capture strobe.

## Test plan
- period=10, enable held, rd_ready=1, counts_in chan k=k+100: cnt_clr pulses every 10 cycles. Each window outputs data 100..103, chan 0..3, rd_last on chan 3. window_seq increments by 1 per window.
- period=4, rd_ready=0 for 20 cycles after the first window: first readout is held stable. overrun_cnt=4 and window_seq=5. Each pulse after the first is an overrun; window_seq counts every window.
- cfg_update with inhibit_len_req=7 mid-window (period=16): inhibit_len changes from 0 to 7 only on the cnt_clr edge. With enable low, the change happens on the next edge.
- enable dropped at timer=5 with period=10: one cnt_clr pulse, no readout, window_seq unchanged. Re-enable: the next cnt_clr comes after 10 full cycles.
- rst asserted during S_RD_SEND word 2: next cycle rd_valid=0, inhibit_len=0, window_seq=0, overrun_cnt=0.
- HDR_EN build, period=8: header word (rd_hdr=1, rd_chan=0xF, data={0,seq}) followed by 4 channel words. A capture on the final handshake edge yields no overrun.
